// File: rtl/rs_issue_unit.sv
// Reservation-station issue unit: two independent entry classes (ALU, branch),
// each tracking busy/ready/payload per entry and issuing round-robin.
module rs_class #(
  parameter int N  = 4,
  parameter int IW = 2,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [DW-1:0]         alloc_data,
  input  logic                  alloc_ops_ready,
  input  logic [N-1:0]          wakeup,
  input  logic                  issue_ready,
  output logic                  issue_valid,
  output logic [DW-1:0]         issue_data,
  output logic [IW-1:0]         issue_idx,
  output logic [N-1:0]          busy_vec,
  output logic                  full,
  output logic                  alloc_err
);
  logic [N-1:0]          busy, rdy, issuable;
  logic [N-1:0][DW-1:0]  payload;
  logic [IW-1:0]         rr_ptr, lock_idx, sel_idx, cand, rr_next;
  logic                  locked, sel_found, one_hot, alloc_ok, issue_fire;

  assign issuable = busy & rdy;
  assign one_hot  = (req != '0) && ((req & (req - 1'b1)) == '0);
  assign alloc_ok = one_hot && ((req & busy) == '0);
  assign alloc_err = (req != '0) && !alloc_ok;

  // Pick the entry to present: a stalled entry stays locked in place,
  // otherwise the first issuable entry at or after rr_ptr (wrapping).
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (locked) begin
      sel_found = 1'b1;
      sel_idx   = lock_idx;
    end else begin
      for (int k = 0; k < N; k++) begin
        cand = IW'((int'(rr_ptr) + k) % N);
        if (!sel_found && issuable[cand]) begin
          sel_found = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  assign issue_fire  = sel_found && issue_ready;
  assign rr_next     = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;
  assign issue_valid = sel_found;
  assign issue_idx   = sel_found ? sel_idx : '0;
  assign issue_data  = sel_found ? payload[sel_idx] : '0;
  assign busy_vec    = busy;
  assign full        = &busy;

  // Entry state: wakeups, then issue (wins over wakeup on the same entry),
  // then allocation, which can only target an entry that was not busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      rdy      <= '0;
      payload  <= '0;
      rr_ptr   <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (busy[i] && wakeup[i]) rdy[i] <= 1'b1;
      if (issue_fire) begin
        busy[sel_idx] <= 1'b0;
        rdy[sel_idx]  <= 1'b0;
        rr_ptr        <= rr_next;
        locked        <= 1'b0;
      end else if (sel_found) begin
        locked   <= 1'b1;
        lock_idx <= sel_idx;
      end
      for (int i = 0; i < N; i++)
        if (alloc_ok && req[i]) begin
          busy[i]    <= 1'b1;
          rdy[i]     <= alloc_ops_ready | wakeup[i];
          payload[i] <= alloc_data;
        end
    end
  end
endmodule

module rs_issue_unit #(
  parameter int WIDTH  = 31,
  parameter int BRANCH = 1,
  parameter int ALU    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALU:0]                ALURequests,
  input  logic [BRANCH:0]             branchRequests,
  input  logic [WIDTH:0]              allocData,
  input  logic                        allocOpsReady,
  input  logic [ALU:0]                ALUWakeup,
  input  logic [BRANCH:0]             branchWakeup,
  input  logic                        ALUIssueReady,
  input  logic                        branchIssueReady,
  output logic                        ALUIssueValid,
  output logic                        branchIssueValid,
  output logic [WIDTH:0]              ALUIssueData,
  output logic [WIDTH:0]              branchIssueData,
  output logic [$clog2(ALU+1)-1:0]    ALUIssueIdx,
  output logic [$clog2(BRANCH+1)-1:0] branchIssueIdx,
  output logic [ALU:0]                ALUBusyVector,
  output logic [BRANCH:0]             branchBusyVector,
  output logic                        ALUFull,
  output logic                        branchFull,
  output logic                        allocError
);
  logic alu_err, br_err;

  rs_class #(.N(ALU+1), .IW($clog2(ALU+1)), .DW(WIDTH+1)) u_alu (
    .clk(clk), .reset(reset), .req(ALURequests), .alloc_data(allocData),
    .alloc_ops_ready(allocOpsReady), .wakeup(ALUWakeup), .issue_ready(ALUIssueReady),
    .issue_valid(ALUIssueValid), .issue_data(ALUIssueData), .issue_idx(ALUIssueIdx),
    .busy_vec(ALUBusyVector), .full(ALUFull), .alloc_err(alu_err)
  );

  rs_class #(.N(BRANCH+1), .IW($clog2(BRANCH+1)), .DW(WIDTH+1)) u_br (
    .clk(clk), .reset(reset), .req(branchRequests), .alloc_data(allocData),
    .alloc_ops_ready(allocOpsReady), .wakeup(branchWakeup), .issue_ready(branchIssueReady),
    .issue_valid(branchIssueValid), .issue_data(branchIssueData), .issue_idx(branchIssueIdx),
    .busy_vec(branchBusyVector), .full(branchFull), .alloc_err(br_err)
  );

  // Sticky error flag: any dropped allocation in either class.
  always_ff @(posedge clk) begin
    if (reset)                allocError <= 1'b0;
    else if (alu_err | br_err) allocError <= 1'b1;
  end
endmodule

// File: tb/tb_rs_issue_unit.sv
// Bench for rs_issue_unit: directed vector table, randomized run against a
// queue/array reference model, and a short hand-written collision sequence.
module tb_rs_issue_unit;
  logic        clk, reset;
  logic [3:0]  ALURequests, ALUWakeup, ALUBusyVector;
  logic [1:0]  branchRequests, branchWakeup, branchBusyVector;
  logic [31:0] allocData, ALUIssueData, branchIssueData;
  logic        allocOpsReady, ALUIssueReady, branchIssueReady;
  logic        ALUIssueValid, branchIssueValid, ALUFull, branchFull, allocError;
  logic [1:0]  ALUIssueIdx;
  logic [0:0]  branchIssueIdx;

  int ntests = 0;
  int nfail  = 0;

  rs_issue_unit dut (
    .clk(clk), .reset(reset), .ALURequests(ALURequests), .branchRequests(branchRequests),
    .allocData(allocData), .allocOpsReady(allocOpsReady), .ALUWakeup(ALUWakeup),
    .branchWakeup(branchWakeup), .ALUIssueReady(ALUIssueReady),
    .branchIssueReady(branchIssueReady), .ALUIssueValid(ALUIssueValid),
    .branchIssueValid(branchIssueValid), .ALUIssueData(ALUIssueData),
    .branchIssueData(branchIssueData), .ALUIssueIdx(ALUIssueIdx),
    .branchIssueIdx(branchIssueIdx), .ALUBusyVector(ALUBusyVector),
    .branchBusyVector(branchBusyVector), .ALUFull(ALUFull), .branchFull(branchFull),
    .allocError(allocError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [3:0] areq; logic [1:0] breq; logic [31:0] data; logic ops;
    logic [3:0] awk; logic [1:0] bwk; logic ardy; logic brdy;
  } in_t;

  typedef struct {
    in_t i;
    logic [3:0] abusy; logic av; logic [1:0] aidx; logic [31:0] adata;
    logic [1:0] bbusy; logic bv; logic bidx; logic [31:0] bdata; logic err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: per class arrays of busy/ready/payload, a round-robin
  // start pointer, and the entry currently held on a stall (-1 = none).
  bit          mb[2][4], mr[2][4];
  logic [31:0] mp[2][4];
  int          mrr[2], mpres[2];
  bit          merr;

  function automatic int ncls(int c); return (c == 0) ? 4 : 2; endfunction

  function automatic int msel(int c);
    if (mpres[c] >= 0) return mpres[c];
    for (int k = 0; k < ncls(c); k++) begin
      int j = (mrr[c] + k) % ncls(c);
      if (mb[c][j] && mr[c][j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input in_t v);
    if (v.rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) begin mb[c][i] = 0; mr[c][i] = 0; mp[c][i] = '0; end
        mrr[c] = 0; mpres[c] = -1;
      end
      merr = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      int n = ncls(c);
      logic [3:0] req = (c == 0) ? v.areq : {2'b00, v.breq};
      logic [3:0] wk  = (c == 0) ? v.awk  : {2'b00, v.bwk};
      bit rdy = (c == 0) ? v.ardy : v.brdy;
      int s = msel(c);
      int cnt = $countones(req);
      bit ob[4];
      for (int i = 0; i < 4; i++) ob[i] = mb[c][i];
      for (int i = 0; i < n; i++) if (ob[i] && wk[i]) mr[c][i] = 1;
      if (s >= 0) begin
        if (rdy) begin
          mb[c][s] = 0; mr[c][s] = 0; mrr[c] = (s + 1) % n; mpres[c] = -1;
        end else mpres[c] = s;
      end
      if (cnt == 1) begin
        for (int t = 0; t < n; t++) if (req[t]) begin
          if (!ob[t]) begin mb[c][t] = 1; mp[c][t] = v.data; mr[c][t] = v.ops | wk[t]; end
          else merr = 1;
        end
      end else if (cnt > 1) merr = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model and the DUT past the edge.
  task automatic apply(input in_t v);
    reset = v.rst; ALURequests = v.areq; branchRequests = v.breq; allocData = v.data;
    allocOpsReady = v.ops; ALUWakeup = v.awk; branchWakeup = v.bwk;
    ALUIssueReady = v.ardy; branchIssueReady = v.brdy;
    model_edge(v);
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < 2; c++) begin
      int s = msel(c);
      logic [3:0] bv = '0;
      for (int i = 0; i < ncls(c); i++) bv[i] = mb[c][i];
      if (c == 0) begin
        chk({tag, " alu_valid"}, 32'(ALUIssueValid), 32'(s >= 0));
        chk({tag, " alu_idx"},   32'(ALUIssueIdx),   (s >= 0) ? 32'(s) : 0);
        chk({tag, " alu_data"},  ALUIssueData,       (s >= 0) ? mp[0][s] : 0);
        chk({tag, " alu_busy"},  32'(ALUBusyVector), 32'(bv));
        chk({tag, " alu_full"},  32'(ALUFull),       32'(bv == 4'hF));
      end else begin
        chk({tag, " br_valid"},  32'(branchIssueValid), 32'(s >= 0));
        chk({tag, " br_idx"},    32'(branchIssueIdx),   (s >= 0) ? 32'(s) : 0);
        chk({tag, " br_data"},   branchIssueData,       (s >= 0) ? mp[1][s] : 0);
        chk({tag, " br_busy"},   32'(branchBusyVector), 32'(bv));
        chk({tag, " br_full"},   32'(branchFull),       32'(bv == 4'h3));
      end
    end
    chk({tag, " alloc_err"}, 32'(allocError), 32'(merr));
  endtask

  function automatic in_t mi(logic rst, logic [3:0] areq, logic [1:0] breq, logic [31:0] d,
                             logic ops, logic [3:0] awk, logic [1:0] bwk, logic ardy, logic brdy);
    in_t r;
    r.rst = rst; r.areq = areq; r.breq = breq; r.data = d; r.ops = ops;
    r.awk = awk; r.bwk = bwk; r.ardy = ardy; r.brdy = brdy;
    return r;
  endfunction

  task automatic add(input in_t i, input logic [3:0] abusy, input logic av, input logic [1:0] aidx,
                     input logic [31:0] adata, input logic [1:0] bbusy, input logic bv,
                     input logic bidx, input logic [31:0] bdata, input logic err);
    vec_t r;
    r.i = i; r.abusy = abusy; r.av = av; r.aidx = aidx; r.adata = adata;
    r.bbusy = bbusy; r.bv = bv; r.bidx = bidx; r.bdata = bdata; r.err = err;
    tbl.push_back(r);
  endtask

  initial begin
    in_t v;
    // rst areq breq data ops awk bwk ardy brdy | abusy av aidx adata | bbusy bv bidx bdata | err
    add(mi(1,0,0,0,0,0,0,0,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,1,0,'h11,1,0,0,0,0),       4'h1,1,0,'h11,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(1,0,0,0,0,0,0,0,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,1,0,'hA0,1,0,0,0,0),       4'h1,1,0,'hA0,  2'h0,0,0,0,     0);
    add(mi(0,4,0,'hA2,1,0,0,0,0),       4'h5,1,0,'hA0,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h4,1,2,'hA2,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,1,0,'hB0,0,0,0,0,0),       4'h1,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,8,0,'hB3,0,0,0,0,0),       4'h9,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,9,0,0,0),          4'h9,1,3,'hB3,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h1,1,0,'hB0,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,2,0,'hC1,0,0,0,0,0),       4'h2,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,0,0),          4'h2,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,2,0,0,0),          4'h2,1,1,'hC1,  2'h0,0,0,0,     0);
    add(mi(0,1,0,'hD0,1,0,0,1,0),       4'h1,1,0,'hD0,  2'h0,0,0,0,     0);
    add(mi(0,8,0,'hD3,0,0,0,0,0),       4'h9,1,0,'hD0,  2'h0,0,0,0,     0);
    add(mi(0,2,0,'hD1,0,0,0,0,0),       4'hB,1,0,'hD0,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,'hA,0,0,0),        4'hB,1,0,'hD0,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'hA,1,1,'hD1,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h8,1,3,'hD3,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,1,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,0,1,'hE0,1,0,0,0,0),       4'h0,0,0,0,     2'h1,1,0,'hE0,  0);
    add(mi(0,0,1,'hEE,1,0,0,0,0),       4'h0,0,0,0,     2'h1,1,0,'hE0,  1);
    add(mi(0,0,2,'hE1,0,0,0,0,0),       4'h0,0,0,0,     2'h3,1,0,'hE0,  1);
    add(mi(0,3,0,'h99,1,0,0,0,0),       4'h0,0,0,0,     2'h3,1,0,'hE0,  1);
    add(mi(0,0,0,0,0,0,0,0,1),          4'h0,0,0,0,     2'h2,0,0,0,     1);
    add(mi(0,0,0,0,0,0,2,0,0),          4'h0,0,0,0,     2'h2,1,1,'hE1,  1);
    add(mi(1,1,0,'h77,1,0,0,1,1),       4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,1,0,'hF0,1,0,0,0,0),       4'h1,1,0,'hF0,  2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,0,0),          4'h1,1,0,'hF0,  2'h0,0,0,0,     0);
    add(mi(1,0,0,0,0,0,0,0,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);
    add(mi(0,0,0,0,0,0,0,0,0),          4'h0,0,0,0,     2'h0,0,0,0,     0);

    for (int r = 0; r < tbl.size(); r++) begin
      string t;
      t = $sformatf("row%0d", r);
      apply(tbl[r].i);
      chk({t, " alu_busy"},  32'(ALUBusyVector),    32'(tbl[r].abusy));
      chk({t, " alu_full"},  32'(ALUFull),          32'(&tbl[r].abusy));
      chk({t, " alu_valid"}, 32'(ALUIssueValid),    32'(tbl[r].av));
      chk({t, " alu_idx"},   32'(ALUIssueIdx),      32'(tbl[r].aidx));
      chk({t, " alu_data"},  ALUIssueData,          tbl[r].adata);
      chk({t, " br_busy"},   32'(branchBusyVector), 32'(tbl[r].bbusy));
      chk({t, " br_full"},   32'(branchFull),       32'(&tbl[r].bbusy));
      chk({t, " br_valid"},  32'(branchIssueValid), 32'(tbl[r].bv));
      chk({t, " br_idx"},    32'(branchIssueIdx),   32'(tbl[r].bidx));
      chk({t, " br_data"},   branchIssueData,       tbl[r].bdata);
      chk({t, " alloc_err"}, 32'(allocError),       32'(tbl[r].err));
    end

    // Randomized run against the reference model.
    apply(mi(1,0,0,0,0,0,0,0,0));
    check_model("rnd_reset");
    for (int cyc = 0; cyc < 400; cyc++) begin
      int sel;
      v = mi(0,0,0,0,0,0,0,0,0);
      v.rst  = ($urandom_range(0, 59) == 0);
      sel    = $urandom_range(0, 9);
      if (sel >= 9)      v.areq = 4'($urandom());
      else if (sel >= 4) v.areq = 4'(1 << $urandom_range(0, 3));
      sel    = $urandom_range(0, 9);
      if (sel >= 9)      v.breq = 2'($urandom());
      else if (sel >= 6) v.breq = 2'(1 << $urandom_range(0, 1));
      v.data = $urandom();
      v.ops  = 1'($urandom());
      v.awk  = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
      v.bwk  = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'h0;
      v.ardy = 1'($urandom());
      v.brdy = 1'($urandom());
      apply(v);
      check_model($sformatf("rnd%0d", cyc));
    end

    // Same-cycle issue of entry 0 with allocation into it (still busy): dropped.
    apply(mi(1,0,0,0,0,0,0,0,0));
    apply(mi(0,1,0,'h5A,1,0,0,0,0));
    apply(mi(0,1,0,'h5B,1,0,0,1,0));
    chk("collide alu_busy", 32'(ALUBusyVector), 32'h0);
    chk("collide err",      32'(allocError),    32'h1);
    // Issue of entry 1 plus allocation of entry 2 in one cycle both land.
    apply(mi(1,0,0,0,0,0,0,0,0));
    apply(mi(0,2,0,'h61,1,0,0,0,0));
    apply(mi(0,4,0,'h62,1,0,0,1,0));
    chk("overlap alu_busy", 32'(ALUBusyVector), 32'h4);
    chk("overlap alu_idx",  32'(ALUIssueIdx),   32'h2);
    chk("overlap alu_data", ALUIssueData,       32'h62);
    chk("overlap err",      32'(allocError),    32'h0);
    // Multi-hot branch request with both entries free allocates nothing.
    apply(mi(0,0,3,'h70,1,0,0,0,0));
    chk("br multihot busy", 32'(branchBusyVector), 32'h0);
    chk("br multihot err",  32'(allocError),       32'h1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
